// File: rtl/multi_bit_debounce.sv
// multi_bit_debounce: N-channel push-button/switch debouncer.
// Each channel has a 2-FF synchroniser, a stability counter, a debounced level,
// one-cycle rise/fall strobes and an optional auto-repeat strobe while held.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   bnc_sign   - raw asynchronous bouncing inputs, one bit per channel
//   debnc_sign - debounced level (registered)
//   rise_pulse - 1-cycle strobe when debnc_sign goes 0->1
//   fall_pulse - 1-cycle strobe when debnc_sign goes 1->0
//   rpt_pulse  - 1-cycle auto-repeat strobe while debnc_sign is held 1
module multi_bit_debounce #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CNT_W      = 21,
  parameter int unsigned STABLE_CNT = 1000000,
  parameter int unsigned ACTIVE_LOW = 0,
  parameter int unsigned REPEAT_EN  = 1,
  parameter int unsigned HOLD_W     = 28,
  parameter int unsigned HOLD_CNT   = 50000000,
  parameter int unsigned REPEAT_CNT = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] bnc_sign,
  output logic [CHANNELS-1:0] debnc_sign,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] rpt_pulse
);

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CHANNELS-1:0] INV_MASK =
    (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CNT_W-1:0]    cnt     [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] debnc_nxt;
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;

  // Stability qualification: a new level must be seen STABLE_CNT cycles in a row.
  always_comb begin
    debnc_nxt = debnc_sign;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != debnc_sign[i]) begin
        if (cnt[i] == CNT_LAST) begin
          debnc_nxt[i] = s2[i];
          rise_nxt[i]  = s2[i];
          fall_nxt[i]  = ~s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser, counters, level and edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      cnt        <= '{default: '0};
      debnc_sign <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      s1         <= bnc_sign ^ INV_MASK;
      s2         <= s1;
      cnt        <= cnt_nxt;
      debnc_sign <= debnc_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CNT - 1);
      localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CNT - REPEAT_CNT);

      logic [HOLD_W-1:0]   hcnt     [CHANNELS];
      logic [HOLD_W-1:0]   hcnt_nxt [CHANNELS];
      logic [CHANNELS-1:0] rpt_nxt;

      // Hold timing runs only while the registered level is 1; the cycle the
      // level rises it is still 0, so the first strobe lands HOLD_CNT edges
      // after rise_pulse. A release on this edge suppresses any repeat.
      always_comb begin
        rpt_nxt = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
          hcnt_nxt[i] = '0;
          if (debnc_sign[i] && !fall_nxt[i]) begin
            if (hcnt[i] == HOLD_LAST) begin
              rpt_nxt[i]  = 1'b1;
              hcnt_nxt[i] = HOLD_RELOAD;
            end else begin
              hcnt_nxt[i] = hcnt[i] + HOLD_W'(1);
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          hcnt      <= '{default: '0};
          rpt_pulse <= '0;
        end else begin
          hcnt      <= hcnt_nxt;
          rpt_pulse <= rpt_nxt;
        end
      end
    end else begin : g_no_repeat
      assign rpt_pulse = '0;
    end
  endgenerate

endmodule

// File: tb/tb_multi_bit_debounce.sv
// Self-checking bench for multi_bit_debounce.
// dut_a: ACTIVE_LOW=0, REPEAT_EN=1 (bench channels 0..3).
// dut_b: ACTIVE_LOW=1, REPEAT_EN=0 (bench channels 4..7).
// Expected strobes are queued with the edge number they must appear on and
// compared every cycle against the concatenated DUT outputs.
module tb_multi_bit_debounce;

  localparam int STABLE = 4;
  localparam int HOLD   = 10;
  localparam int RPT    = 5;
  localparam int LAT    = STABLE + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bnc_a = 4'h0;
  logic [3:0] bnc_b = 4'hF;
  logic [3:0] lvl_a, rise_a, fall_a, rpt_a;
  logic [3:0] lvl_b, rise_b, fall_b, rpt_b;

  multi_bit_debounce #(
    .CHANNELS(4), .CNT_W(3), .STABLE_CNT(STABLE), .ACTIVE_LOW(0), .REPEAT_EN(1),
    .HOLD_W(4), .HOLD_CNT(HOLD), .REPEAT_CNT(RPT)
  ) dut_a (
    .clk(clk), .rst(rst), .bnc_sign(bnc_a), .debnc_sign(lvl_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .rpt_pulse(rpt_a)
  );

  multi_bit_debounce #(
    .CHANNELS(4), .CNT_W(3), .STABLE_CNT(STABLE), .ACTIVE_LOW(1), .REPEAT_EN(0),
    .HOLD_W(4), .HOLD_CNT(HOLD), .REPEAT_CNT(RPT)
  ) dut_b (
    .clk(clk), .rst(rst), .bnc_sign(bnc_b), .debnc_sign(lvl_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .rpt_pulse(rpt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    int ch;
    int kind;   // 0 rise, 1 fall, 2 repeat
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_lvl = '0;
  logic [7:0] exp_r, exp_f, exp_p;
  logic       rst_s;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Stimulus-side expectation builders; called at a negedge following edge cyc.
  task automatic push_press(input int ch);
    ev_t e;
    e.at = cyc + LAT; e.ch = ch; e.kind = 0;
    q.push_back(e);
    if (ch < 4) begin
      for (int k = 0; k < 40; k++) begin
        e.at = cyc + LAT + HOLD + k * RPT; e.ch = ch; e.kind = 2;
        q.push_back(e);
      end
    end
  endtask

  task automatic push_release(input int ch);
    ev_t e;
    int  fall_at;
    fall_at = cyc + LAT;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].ch == ch && q[i].kind == 2 && q[i].at >= fall_at) q.delete(i);
    e.at = fall_at; e.ch = ch; e.kind = 1;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: build expected strobes for this edge and compare all outputs.
  always @(posedge clk) begin
    rst_s = rst;
    cyc++;
    #1;
    exp_r = '0; exp_f = '0; exp_p = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc) begin
        case (q[i].kind)
          0: begin exp_r[q[i].ch] = 1'b1; exp_lvl[q[i].ch] = 1'b1; end
          1: begin exp_f[q[i].ch] = 1'b1; exp_lvl[q[i].ch] = 1'b0; end
          default: exp_p[q[i].ch] = 1'b1;
        endcase
        q.delete(i);
      end
    end
    if (rst_s) exp_lvl = '0;
    check("level", {lvl_b, lvl_a}, exp_lvl);
    check("rise",  {rise_b, rise_a}, exp_r);
    check("fall",  {fall_b, fall_a}, exp_f);
    check("rpt",   {rpt_b, rpt_a}, exp_p);
  end

  logic [5:0] bounce;

  initial begin
    bounce = 6'b101101;   // applied LSB first: 1,0,1,1,0,1
    wait_cyc(3);
    rst = 1'b0;

    // Clean step on ch0, then release.
    bnc_a[0] = 1'b1; push_press(0);
    wait_cyc(8);
    bnc_a[0] = 1'b0; push_release(0);
    wait_cyc(8);

    // Bouncing press on ch1: only the final steady 1 qualifies.
    for (int i = 0; i < 6; i++) begin
      bnc_a[1] = bounce[i];
      if (i == 5) push_press(1);
      wait_cyc(1);
    end
    wait_cyc(10);

    // 3-cycle glitch on ch0 is rejected.
    bnc_a[0] = 1'b1;
    wait_cyc(3);
    bnc_a[0] = 1'b0;
    wait_cyc(8);

    // Simultaneous rise on ch0/ch3 and fall on ch1.
    bnc_a[0] = 1'b1; push_press(0);
    bnc_a[3] = 1'b1; push_press(3);
    bnc_a[1] = 1'b0; push_release(1);
    wait_cyc(8);
    bnc_a[0] = 1'b0; push_release(0);
    bnc_a[3] = 1'b0; push_release(3);
    wait_cyc(10);

    // Hold on ch2: repeats at +16,+21,+26; the release lands on the would-be
    // +31 repeat, which must be suppressed.
    bnc_a[2] = 1'b1; push_press(2);
    wait_cyc(25);
    bnc_a[2] = 1'b0; push_release(2);
    wait_cyc(12);

    // Reset mid-hold (hcnt=7), input stays high, re-qualifies from zero.
    bnc_a[2] = 1'b1; push_press(2);
    wait_cyc(13);
    rst = 1'b1; q.delete();
    wait_cyc(1);
    rst = 1'b0; push_press(2);
    wait_cyc(18);
    bnc_a[2] = 1'b0; push_release(2);
    wait_cyc(10);

    // Active-low instance without repeat: press ch4/ch6 pins (1->0), hold long.
    bnc_b[0] = 1'b0; push_press(4);
    bnc_b[2] = 1'b0; push_press(6);
    wait_cyc(24);
    bnc_b[0] = 1'b1; push_release(4);
    bnc_b[2] = 1'b1; push_release(6);
    wait_cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
